// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared encodings and widths for the writeback/register-file slice
package writeback_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_NONE = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_regfile_load_align.sv
// rtl/writeback_regfile_load_align.sv - load lane select and sign/zero extension
module load_align
  import writeback_regfile_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
    // Halfword loads are always naturally aligned; the low address bit carries no information.
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {24'h000000, byte_v};
      F3_LH:   data_o = {{16{half_v[15]}}, half_v};
      F3_LHU:  data_o = {16'h0000, half_v};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - register-file write end: retire, bypassed reads, pending-write scoreboard, instret
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_load,
  input  logic [2:0]      wb_funct3,
  input  logic [1:0]      wb_addr_lo,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [63:0]     instret
);

  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_FULL = '1;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [63:0]       instret_q, instret_d;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wr_data;
  logic            wr_en;
  logic            inc;

  load_align u_load_align (
    .funct3_i  (wb_funct3),
    .addr_lo_i (wb_addr_lo),
    .word_i    (wb_load),
    .data_o    (load_data)
  );

  always_comb begin
    case (wb_sel)
      WB_SEL_ALU:  wr_data = wb_alu;
      WB_SEL_LOAD: wr_data = load_data;
      WB_SEL_PC4:  wr_data = wb_pc + XLEN'(4);
      default:     wr_data = '0;
    endcase
  end

  // A retiring write also releases its scoreboard claim, so wr_en doubles as the decrement.
  assign wr_en = wb_valid && (wb_sel != WB_SEL_NONE) && (wb_rd != 5'd0);

  assign iss_ready = !((iss_rd != 5'd0) && (pend_q[iss_rd] == PEND_FULL) &&
                       !(wr_en && (wb_rd == iss_rd)));
  assign inc = iss_valid && iss_ready && (iss_rd != 5'd0);

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    if (a == 5'd0)
      read_port = '0;
    else if (wr_en && (wb_rd == a))
      read_port = wr_data;
    else
      read_port = regs_q[a];
  endfunction

  function automatic logic busy_of(input logic [4:0] a);
    busy_of = (a != 5'd0) && (pend_q[a] != '0) &&
              !((pend_q[a] == PEND_ONE) && wr_en && (wb_rd == a));
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
    rs1_busy = busy_of(rs1_addr);
    rs2_busy = busy_of(rs2_addr);
  end

  always_comb begin
    pend_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (inc && (iss_rd == REG_IDX_W'(r)) && !(wr_en && (wb_rd == REG_IDX_W'(r))))
        pend_d[r] = pend_q[r] + PEND_ONE;
      else if (wr_en && (wb_rd == REG_IDX_W'(r)) && !(inc && (iss_rd == REG_IDX_W'(r))) &&
               (pend_q[r] != '0))
        pend_d[r] = pend_q[r] - PEND_ONE;
    end
  end

  assign instret_d = wb_valid ? instret_q + 64'd1 : instret_q;
  assign instret   = instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      instret_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        pend_q[r] <= pend_d[r];
      if (wr_en)
        regs_q[wb_rd] <= wr_data;
      instret_q <= instret_d;
    end
  end

`ifndef SYNTHESIS
  // Retiring a write that was never claimed means decode and writeback disagree on the scoreboard.
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
    !(wr_en && (pend_q[wb_rd] == '0) && !(inc && (iss_rd == wb_rd))))
    else $error("scoreboard underflow on x%0d", wb_rd);
`endif

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write end of the integer register file that the decode stage reads.
- Retires one result per cycle from the memory stage and formats load data (byte/half extraction, sign or zero extension).
- Writes x1..x31 and presents two combinational read ports with write-through bypass back to decode.
- Keeps a per-register pending-write scoreboard that decode claims at issue, plus a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, register and data width
- NREG, 32, number of architectural registers (x0 hardwired zero)
- PEND_W, 2, width of per-register pending-write counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- iss_valid  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  5  destination register claimed at issue
- iss_ready  out  1  claim accepted this cycle
- wb_valid  in  1  memory stage presents a retiring instruction
- wb_rd  in  5  destination register (0 = no write)
- wb_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 none
- wb_alu  in  32  ALU result
- wb_load  in  32  raw aligned memory word
- wb_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- wb_addr_lo  in  2  load byte address [1:0]
- wb_pc  in  32  instruction PC
- rs1_addr, rs2_addr  in  5  read addresses
- rs1_data, rs2_data  out  32  read data, bypassed
- rs1_busy, rs2_busy  out  1  register has a pending write not completing this cycle
- instret  out  64  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous):
  - x1..x31 = 0, all pending counters = 0, instret = 0.
  - Outputs follow from the cleared state: iss_ready=1, busy=0, read data=0.
  - Reset mid-operation discards all in-flight claims.
- Write data:
  - sel=0: wb_alu. sel=2: wb_pc+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000). sel=3: no register write.
  - sel=1, LB/LBU: byte lane wb_addr_lo.
  - sel=1, LH/LHU: half lane wb_addr_lo[1]; wb_addr_lo[0] ignored.
  - sel=1, LW: whole word; wb_addr_lo ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend. Other funct3 codes write the raw word.
- Register write: on the clk rising edge when wb_valid && wb_sel!=3 && wb_rd!=0. Writes to x0 are dropped.
- Read ports (combinational):
  - addr 0 -> 0.
  - addr == wb_rd with a write occurring this cycle -> formatted write data (write-through).
  - otherwise the register contents.
- Scoreboard: pend[r] is PEND_W bits, r=1..31; x0 is never tracked.
  - inc = iss_valid && iss_ready && iss_rd!=0.
  - dec = wb_valid && wb_sel!=3 && wb_rd!=0.
  - Same register incremented and decremented in one cycle -> unchanged.
  - iss_ready = 0 when iss_rd!=0 and pend[iss_rd] is all-ones and that register is not decremented this cycle; otherwise 1.
  - Decrement at pend=0 is a protocol error: counter stays 0 (no wrap). Assertion fires in simulation.
- Busy: rsN_busy = pend[addr]!=0 and not (pend[addr]==1 and dec on addr this cycle). Address 0 -> busy=0.
- instret: increments by 1 on every wb_valid cycle, including rd=0 and sel=3. Wraps at 2^64-1 -> 0.
- Latency:
  - Write visible on the read ports in the same cycle via bypass, and from the register array on the next cycle.
  - Scoreboard and instret update on the next edge.

Decomposition:
- Shared package: WB_SEL_ALU/LOAD/PC4/NONE encodings, funct3 load constants, XLEN, register-index type.
- Sub-module load_align: combinational lane select and extension. Inputs funct3, addr_lo, word; output 32-bit data.
- Register array, scoreboard and counter stay in the top module.

Test Plan:
- Reset release, read x5 -> 0; wb_valid rd=5 sel=0 alu=0xDEADBEEF; same cycle rs1_addr=5 -> rs1_data=0xDEADBEEF (bypass), following cycle still 0xDEADBEEF; instret=1.
- Write rd=0 alu=0x12345678 -> rs1_addr=0 reads 0; instret increments; no busy change.
- wb_load=0x80FF7F01, sel=1:
  - LB addr_lo=3 -> 0xFFFFFF80; LBU addr_lo=3 -> 0x00000080.
  - LH addr_lo=2 -> 0xFFFF80FF; LHU addr_lo=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Issue rd=7 three times -> pend=3, rs2_busy=1; fourth issue -> iss_ready=0.
  - Same cycle as that fourth issue, retire rd=7 -> iss_ready=1, pend stays 3.
  - Three more retires -> busy clears on the cycle of the last retire.
- sel=2, wb_pc=0x00001000, rd=1 -> x1=0x00001004; wb_pc=0xFFFFFFFC -> x1=0.
- Issue rd=9, assert reset low mid-cycle -> pend, registers and instret clear asynchronously; rs1_busy=0 immediately.
